// File: rtl/scr1_tb_ahb_mailbox.sv
// AHB-Lite mailbox slave for the SCR1 bench: TOHOST result, console FIFO, cycle counter, status.
// Console FIFO and CONSOLE register exist only when SCR1_TB_MBOX_CONSOLE_EN is defined.
module scr1_tb_ahb_mailbox #(
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hsel,
    input  logic [1:0]  htrans,
    input  logic [31:0] haddr,
    input  logic [2:0]  hsize,
    input  logic        hwrite,
    input  logic [31:0] hwdata,
    output logic        hready,
    output logic [31:0] hrdata,
    output logic        hresp,
    output logic        test_done,
    output logic        test_pass,
    output logic [31:0] test_code,
    output logic        con_valid,
    output logic [7:0]  con_data,
    input  logic        con_ready
);
    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_XFER = 2'd1;
    localparam logic [1:0] ST_ERR1 = 2'd2;
    localparam logic [1:0] ST_ERR2 = 2'd3;

    localparam logic [1:0] OFF_TOHOST  = 2'd0;
    localparam logic [1:0] OFF_CONSOLE = 2'd1;
    localparam logic [1:0] OFF_CYCLES  = 2'd2;
    localparam logic [1:0] OFF_STATUS  = 2'd3;

`ifdef SCR1_TB_MBOX_CONSOLE_EN
    localparam logic CONSOLE_EN = 1'b1;
`else
    localparam logic CONSOLE_EN = 1'b0;
`endif

    function automatic logic access_err(input logic [3:0] a, input logic [2:0] sz,
                                        input logic wr, input logic con_en);
        logic ro_s;
        logic wo_s;
        ro_s = (a[3:2] == OFF_CYCLES) || (a[3:2] == OFF_STATUS);
        wo_s = (a[3:2] == OFF_TOHOST) || (a[3:2] == OFF_CONSOLE);
        return (a[1:0] != 2'd0) || (sz > 3'd2) || (wr ? ro_s : wo_s)
               || (!con_en && (a[3:2] == OFF_CONSOLE));
    endfunction

    logic [1:0]  state_q, state_d;
    logic [1:0]  off_q, off_d;
    logic        wr_q, wr_d;
    logic [31:0] cycles_q, cycles_d;
    logic        done_q, done_d;
    logic        pass_q, pass_d;
    logic [31:0] code_q, code_d;

    logic        addr_ph_s;
    logic        addr_err_s;
    logic        wr_done_s;
    logic        full_s;
    logic        empty_s;
    logic        pop_s;
    logic [AW:0] count_s;
    logic [31:0] status_s;
    logic        unused_s;

    assign addr_ph_s  = hsel & htrans[1] & hready;
    assign addr_err_s = access_err(haddr[3:0], hsize, hwrite, CONSOLE_EN);
    assign wr_done_s  = (state_q == ST_XFER) & hready & wr_q;

    assign test_done = done_q;
    assign test_pass = pass_q;
    assign test_code = code_q;

    // Data-phase handshake; a CONSOLE write waits for FIFO room or a same-cycle pop
    always_comb begin
        hready = 1'b1;
        hresp  = 1'b0;
        case (state_q)
            ST_XFER: begin
                if (wr_q && (off_q == OFF_CONSOLE)) begin
                    hready = ~full_s | pop_s;
                end else begin
                    hready = 1'b1;
                end
            end
            ST_ERR1: begin
                hready = 1'b0;
                hresp  = 1'b1;
            end
            ST_ERR2: begin
                hresp  = 1'b1;
            end
            default: begin
                hready = 1'b1;
                hresp  = 1'b0;
            end
        endcase
    end

    // Next data-phase state and captured address-phase attributes
    always_comb begin
        state_d = state_q;
        off_d   = off_q;
        wr_d    = wr_q;
        if (state_q == ST_ERR1) begin
            state_d = ST_ERR2;
        end else if (!hready) begin
            state_d = state_q;
        end else if (addr_ph_s) begin
            state_d = addr_err_s ? ST_ERR1 : ST_XFER;
            off_d   = haddr[3:2];
            wr_d    = hwrite;
        end else begin
            state_d = ST_IDLE;
        end
    end

    // TOHOST capture (first write only) and free-running counter
    always_comb begin
        cycles_d = cycles_q + 32'd1;
        done_d   = done_q;
        pass_d   = pass_q;
        code_d   = code_q;
        if (wr_done_s && (off_q == OFF_TOHOST) && !done_q) begin
            done_d = 1'b1;
            pass_d = (hwdata == 32'd1);
            code_d = hwdata;
        end else begin
            done_d = done_q;
        end
    end

    // Status word and read-data mux, zero outside read data phases
    always_comb begin
        status_s       = 32'h0000_0000;
        status_s[0]    = done_q;
        status_s[1]    = full_s;
        status_s[2]    = empty_s;
        status_s[15:8] = {{(7 - AW){1'b0}}, count_s};
        hrdata         = 32'h0000_0000;
        if ((state_q == ST_XFER) && !wr_q) begin
            case (off_q)
                OFF_CYCLES: hrdata = cycles_q;
                OFF_STATUS: hrdata = status_s;
                default:    hrdata = 32'h0000_0000;
            endcase
        end else begin
            hrdata = 32'h0000_0000;
        end
    end

    // Control and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            off_q    <= 2'd0;
            wr_q     <= 1'b0;
            cycles_q <= 32'h0000_0000;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            code_q   <= 32'h0000_0000;
        end else begin
            state_q  <= state_d;
            off_q    <= off_d;
            wr_q     <= wr_d;
            cycles_q <= cycles_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
            code_q   <= code_d;
        end
    end

`ifdef SCR1_TB_MBOX_CONSOLE_EN
    logic [7:0]    fifo_mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic          push_s;

    assign push_s    = wr_done_s & (off_q == OFF_CONSOLE);
    assign full_s    = (count_q == (AW + 1)'(FIFO_DEPTH));
    assign empty_s   = (count_q == '0);
    assign count_s   = count_q;
    assign con_valid = ~empty_s;
    assign pop_s     = con_valid & con_ready;
    assign con_data  = empty_s ? 8'h00 : fifo_mem_q[rd_ptr_q];
    assign unused_s  = ^{htrans[0], haddr[31:4]};

    // FIFO storage; contents need no reset since the head is masked while empty
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_mem_q[wr_ptr_q] <= hwdata[7:0];
        end
    end

    // FIFO pointers and occupancy; power-of-2 depth lets the pointers wrap naturally
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_q <= count_q + (AW + 1)'(1);
                2'b01:   count_q <= count_q - (AW + 1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end
`else
    assign full_s    = 1'b0;
    assign empty_s   = 1'b1;
    assign count_s   = '0;
    assign pop_s     = 1'b0;
    assign con_valid = 1'b0;
    assign con_data  = 8'h00;
    assign unused_s  = ^{htrans[0], haddr[31:4], con_ready};
`endif

endmodule

// File: tb/tb_scr1_tb_ahb_mailbox.sv
// Self-checking bench for scr1_tb_ahb_mailbox: register map, error responses, console stream.
module tb_scr1_tb_ahb_mailbox;
    logic        clk;
    logic        rst;
    logic        hsel;
    logic [1:0]  htrans;
    logic [31:0] haddr;
    logic [2:0]  hsize;
    logic        hwrite;
    logic [31:0] hwdata;
    logic        hready;
    logic [31:0] hrdata;
    logic        hresp;
    logic        test_done;
    logic        test_pass;
    logic [31:0] test_code;
    logic        con_valid;
    logic [7:0]  con_data;
    logic        con_ready;

    int n_vec = 0;
    int n_miss = 0;
    int tb_cyc = 0;
    int rst_cyc = 0;

    typedef struct packed {
        logic        err;
        logic [31:0] data;
    } exp_t;

    exp_t       sbq[$];
    logic [7:0] con_q[$];

    scr1_tb_ahb_mailbox #(.FIFO_DEPTH(8)) dut (
        .clk(clk), .rst(rst), .hsel(hsel), .htrans(htrans), .haddr(haddr),
        .hsize(hsize), .hwrite(hwrite), .hwdata(hwdata), .hready(hready),
        .hrdata(hrdata), .hresp(hresp), .test_done(test_done), .test_pass(test_pass),
        .test_code(test_code), .con_valid(con_valid), .con_data(con_data),
        .con_ready(con_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // cycle index and the index of the last edge that saw reset
    always @(posedge clk) begin
        tb_cyc <= tb_cyc + 1;
        if (rst) rst_cyc <= tb_cyc + 1;
    end

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; hsel = 1'b0; htrans = 2'b00; con_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // one non-pipelined transfer; returns data-phase observations
    task automatic bus(input logic [31:0] a, input logic [2:0] sz, input logic wr,
                       input logic [31:0] wd, output logic [31:0] rd, output logic rsp,
                       output int waits, output logic resp0, output int ts);
        @(posedge clk); #1;
        hsel = 1'b1; htrans = 2'b10; haddr = a; hsize = sz; hwrite = wr;
        @(posedge clk); #1;
        hsel = 1'b0; htrans = 2'b00; hwdata = wd;
        waits = 0;
        @(negedge clk);
        resp0 = hresp;
        while (hready !== 1'b1 && waits < 50) begin
            waits++;
            @(negedge clk);
        end
        rd = hrdata; rsp = hresp; ts = tb_cyc;
        if (waits >= 50) begin
            n_vec++; n_miss++;
            $display("FAIL bus_timeout: addr %h still waiting after %0d cycles, expected completion", a, waits);
        end
    endtask

    task automatic test_reset();
        logic [31:0] rd; logic rsp, r0; int w, ts;
        @(negedge clk);
        n_vec++;
        if (hready !== 1'b1 || hresp !== 1'b0 || hrdata !== 32'h0) begin
            n_miss++;
            $display("FAIL reset_bus: got hready=%b hresp=%b hrdata=%h, expected 1 0 00000000", hready, hresp, hrdata);
        end
        n_vec++;
        if (test_done !== 1'b0 || test_pass !== 1'b0 || test_code !== 32'h0) begin
            n_miss++;
            $display("FAIL reset_result: got done=%b pass=%b code=%h, expected 0 0 00000000", test_done, test_pass, test_code);
        end
        n_vec++;
        if (con_valid !== 1'b0 || con_data !== 8'h00) begin
            n_miss++;
            $display("FAIL reset_console: got valid=%b data=%h, expected 0 00", con_valid, con_data);
        end
        bus(32'hC, 3'd2, 1'b0, 32'h0, rd, rsp, w, r0, ts);
        n_vec++;
        if (rd !== 32'h0000_0004 || rsp !== 1'b0 || w != 0) begin
            n_miss++;
            $display("FAIL reset_status: got %h resp=%b waits=%0d, expected 00000004 0 0", rd, rsp, w);
        end
    endtask

    task automatic test_cycles();
        logic [31:0] rd1, rd2; logic rsp, r0; int w, ts1, ts2;
        bus(32'h8, 3'd2, 1'b0, 32'h0, rd1, rsp, w, r0, ts1);
        n_vec++;
        if (rd1 !== 32'(ts1 - rst_cyc) || rsp !== 1'b0) begin
            n_miss++;
            $display("FAIL cycles_abs: got %h resp=%b, expected %h 0", rd1, rsp, 32'(ts1 - rst_cyc));
        end
        repeat (10) @(posedge clk);
        bus(32'h8, 3'd2, 1'b0, 32'h0, rd2, rsp, w, r0, ts2);
        n_vec++;
        if ((rd2 - rd1) !== 32'(ts2 - ts1)) begin
            n_miss++;
            $display("FAIL cycles_diff: got %0d, expected %0d", rd2 - rd1, ts2 - ts1);
        end
    endtask

    // pipelined sequence incl. errors; expectations queued at address acceptance
    task automatic test_back_to_back();
        logic [31:0] op_a [5];
        logic        op_w [5];
        logic        op_e [5];
        logic [31:0] op_d [5];
        exp_t e;
        int   k = 0;
        int   err_stage = 0;
        logic drv = 1'b0;
        logic hr_prev = 1'b1;
        op_a = '{32'hC, 32'h0, 32'h8, 32'h8, 32'hC};
        op_w = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        op_e = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        op_d = '{32'h4, 32'h0, 32'h0, 32'h0, 32'h4};
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(posedge clk); #1;
            if (drv && hr_prev) begin
                e.err  = op_e[k];
                e.data = (op_a[k] == 32'h8 && !op_e[k]) ? 32'(tb_cyc - rst_cyc) : op_d[k];
                sbq.push_back(e);
                k++;
                drv = 1'b0;
            end
            if (k < 5) begin
                hsel = 1'b1; htrans = 2'b10; haddr = op_a[k]; hsize = 3'd2;
                hwrite = op_w[k]; hwdata = 32'hDEAD_BEEF; drv = 1'b1;
            end else begin
                hsel = 1'b0; htrans = 2'b00;
            end
            @(negedge clk);
            hr_prev = hready;
            if (sbq.size() > 0) begin
                e = sbq[0];
                if (e.err && err_stage == 0) begin
                    n_vec++;
                    if (hready !== 1'b0 || hresp !== 1'b1) begin
                        n_miss++;
                        $display("FAIL b2b_err1 op%0d: got hready=%b hresp=%b, expected 0 1", k - 1, hready, hresp);
                    end
                    err_stage = 1;
                end else if (e.err) begin
                    n_vec++;
                    if (hready !== 1'b1 || hresp !== 1'b1) begin
                        n_miss++;
                        $display("FAIL b2b_err2 op%0d: got hready=%b hresp=%b, expected 1 1", k - 1, hready, hresp);
                    end
                    err_stage = 0;
                    void'(sbq.pop_front());
                end else begin
                    n_vec++;
                    if (hready !== 1'b1 || hresp !== 1'b0 || hrdata !== e.data) begin
                        n_miss++;
                        $display("FAIL b2b_read: got hready=%b hresp=%b data=%h, expected 1 0 %h", hready, hresp, hrdata, e.data);
                    end
                    void'(sbq.pop_front());
                end
            end
            if (k == 5 && sbq.size() == 0) break;
        end
        n_vec++;
        if (k != 5 || sbq.size() != 0) begin
            n_miss++;
            $display("FAIL b2b_done: issued %0d pending %0d, expected 5 0", k, sbq.size());
        end
    endtask

    task automatic test_errors();
        logic [31:0] ea [5];
        logic [2:0]  es [5];
        logic        ew [5];
        logic [31:0] rd; logic rsp, r0; int w, ts;
        ea = '{32'h0, 32'hC, 32'h2, 32'h8, 32'h1};
        es = '{3'd2, 3'd2, 3'd2, 3'd3, 3'd0};
        ew = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 5; i++) begin
            bus(ea[i], es[i], ew[i], 32'h1, rd, rsp, w, r0, ts);
            n_vec++;
            if (w != 1 || r0 !== 1'b1 || rsp !== 1'b1 || rd !== 32'h0) begin
                n_miss++;
                $display("FAIL err_resp%0d: got waits=%0d resp=%b,%b data=%h, expected 1 1,1 00000000", i, w, r0, rsp, rd);
            end
        end
        @(negedge clk);
        n_vec++;
        if (test_done !== 1'b0 || test_code !== 32'h0) begin
            n_miss++;
            $display("FAIL err_noeffect: got done=%b code=%h, expected 0 00000000", test_done, test_code);
        end
        bus(32'hC, 3'd2, 1'b0, 32'h0, rd, rsp, w, r0, ts);
        n_vec++;
        if (rd !== 32'h4 || rsp !== 1'b0) begin
            n_miss++;
            $display("FAIL err_status: got %h resp=%b, expected 00000004 0", rd, rsp);
        end
    endtask

    task automatic test_tohost_pass();
        logic [31:0] rd; logic rsp, r0; int w, ts;
        bus(32'h0, 3'd2, 1'b1, 32'h1, rd, rsp, w, r0, ts);
        n_vec++;
        if (rsp !== 1'b0 || w != 0 || test_done !== 1'b0) begin
            n_miss++;
            $display("FAIL tohost_dphase: got resp=%b waits=%0d done=%b, expected 0 0 0", rsp, w, test_done);
        end
        @(negedge clk);
        n_vec++;
        if (test_done !== 1'b1 || test_pass !== 1'b1 || test_code !== 32'h1) begin
            n_miss++;
            $display("FAIL tohost_pass: got done=%b pass=%b code=%h, expected 1 1 00000001", test_done, test_pass, test_code);
        end
        bus(32'h0, 3'd2, 1'b1, 32'h2, rd, rsp, w, r0, ts);
        @(negedge clk);
        n_vec++;
        if (rsp !== 1'b0 || test_done !== 1'b1 || test_pass !== 1'b1 || test_code !== 32'h1) begin
            n_miss++;
            $display("FAIL tohost_sticky: got resp=%b done=%b pass=%b code=%h, expected 0 1 1 00000001", rsp, test_done, test_pass, test_code);
        end
        bus(32'hC, 3'd2, 1'b0, 32'h0, rd, rsp, w, r0, ts);
        n_vec++;
        if (rd !== 32'h5) begin
            n_miss++;
            $display("FAIL tohost_status: got %h, expected 00000005", rd);
        end
    endtask

    task automatic test_tohost_fail();
        logic [31:0] rd; logic rsp, r0; int w, ts;
        bus(32'h0, 3'd2, 1'b1, 32'h5, rd, rsp, w, r0, ts);
        @(negedge clk);
        n_vec++;
        if (rsp !== 1'b0 || test_done !== 1'b1 || test_pass !== 1'b0 || test_code !== 32'h5) begin
            n_miss++;
            $display("FAIL tohost_fail: got resp=%b done=%b pass=%b code=%h, expected 0 1 0 00000005", rsp, test_done, test_pass, test_code);
        end
    endtask

`ifdef SCR1_TB_MBOX_CONSOLE_EN
    task automatic test_console();
        logic [31:0] rd; logic rsp, r0; int w, ts;
        logic [7:0] b;
        logic exp_hr;
        con_ready = 1'b0;
        @(posedge clk); #1;
        hsel = 1'b1; htrans = 2'b10; haddr = 32'h4; hsize = 3'd0; hwrite = 1'b1;
        for (int i = 0; i < 9; i++) begin
            @(posedge clk); #1;
            b = 8'h41 + i[7:0];
            hwdata = {24'hABCDEF, b};
            con_q.push_back(b);
            hsize = (i % 2 == 0) ? 3'd2 : 3'd0;
            if (i == 8) begin
                hsel = 1'b0; htrans = 2'b00;
            end
            exp_hr = (i < 8) ? 1'b1 : 1'b0;
            @(negedge clk);
            n_vec++;
            if (hready !== exp_hr || hresp !== 1'b0) begin
                n_miss++;
                $display("FAIL con_write%0d: got hready=%b hresp=%b, expected %b 0", i, hready, hresp, exp_hr);
            end
        end
        repeat (3) begin
            @(negedge clk);
            n_vec++;
            if (hready !== 1'b0 || con_valid !== 1'b1 || con_data !== 8'h41) begin
                n_miss++;
                $display("FAIL con_stall: got hready=%b valid=%b data=%h, expected 0 1 41", hready, con_valid, con_data);
            end
        end
        @(posedge clk); #1;
        con_ready = 1'b1;
        @(negedge clk);
        b = (con_q.size() > 0) ? con_q.pop_front() : 8'h00;
        n_vec++;
        if (hready !== 1'b1 || con_valid !== 1'b1 || con_data !== b) begin
            n_miss++;
            $display("FAIL con_release: got hready=%b valid=%b data=%h, expected 1 1 %h", hready, con_valid, con_data, b);
        end
        @(posedge clk); #1;
        con_ready = 1'b0;
        bus(32'hC, 3'd2, 1'b0, 32'h0, rd, rsp, w, r0, ts);
        n_vec++;
        if (rd !== 32'h0000_0802 || rsp !== 1'b0) begin
            n_miss++;
            $display("FAIL con_status_full: got %h resp=%b, expected 00000802 0", rd, rsp);
        end
        @(posedge clk); #1;
        con_ready = 1'b1;
        for (int g = 0; g < 40; g++) begin
            @(negedge clk);
            if (con_valid !== 1'b1) break;
            n_vec++;
            if (con_q.size() == 0) begin
                n_miss++;
                $display("FAIL con_extra: got byte %h, expected no more data", con_data);
            end else begin
                b = con_q.pop_front();
                if (con_data !== b) begin
                    n_miss++;
                    $display("FAIL con_data: got %h, expected %h", con_data, b);
                end
            end
        end
        n_vec++;
        if (con_q.size() != 0) begin
            n_miss++;
            $display("FAIL con_drain: got %0d bytes left, expected 0", con_q.size());
        end
        bus(32'hC, 3'd2, 1'b0, 32'h0, rd, rsp, w, r0, ts);
        n_vec++;
        if (rd !== 32'h4) begin
            n_miss++;
            $display("FAIL con_status_empty: got %h, expected 00000004", rd);
        end
    endtask

    task automatic test_reset_stall();
        logic [31:0] rd; logic rsp, r0; int w, ts;
        int bad = 0;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            bus(32'h4, 3'd0, 1'b1, 32'h60 + i, rd, rsp, w, r0, ts);
            if (rsp !== 1'b0 || w != 0) bad++;
        end
        n_vec++;
        if (bad != 0) begin
            n_miss++;
            $display("FAIL fill_writes: got %0d bad writes, expected 0", bad);
        end
        @(posedge clk); #1;
        hsel = 1'b1; htrans = 2'b10; haddr = 32'h4; hsize = 3'd2; hwrite = 1'b1;
        @(posedge clk); #1;
        hsel = 1'b0; htrans = 2'b00; hwdata = 32'h7A;
        @(negedge clk);
        n_vec++;
        if (hready !== 1'b0) begin
            n_miss++;
            $display("FAIL rst_stall_pre: got hready=%b, expected 0", hready);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        n_vec++;
        if (hready !== 1'b1 || hresp !== 1'b0 || con_valid !== 1'b0 || con_data !== 8'h00) begin
            n_miss++;
            $display("FAIL rst_stall_post: got hready=%b hresp=%b valid=%b data=%h, expected 1 0 0 00", hready, hresp, con_valid, con_data);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        bus(32'hC, 3'd2, 1'b0, 32'h0, rd, rsp, w, r0, ts);
        n_vec++;
        if (rd !== 32'h4 || rsp !== 1'b0) begin
            n_miss++;
            $display("FAIL rst_stall_status: got %h resp=%b, expected 00000004 0", rd, rsp);
        end
    endtask
`else
    task automatic test_console_disabled();
        logic [31:0] rd; logic rsp, r0; int w, ts;
        con_ready = 1'b1;
        bus(32'h4, 3'd0, 1'b1, 32'h55, rd, rsp, w, r0, ts);
        n_vec++;
        if (w != 1 || r0 !== 1'b1 || rsp !== 1'b1) begin
            n_miss++;
            $display("FAIL con_off_write: got waits=%0d resp=%b,%b, expected 1 1,1", w, r0, rsp);
        end
        @(negedge clk);
        n_vec++;
        if (con_valid !== 1'b0 || con_data !== 8'h00) begin
            n_miss++;
            $display("FAIL con_off_out: got valid=%b data=%h, expected 0 00", con_valid, con_data);
        end
        bus(32'hC, 3'd2, 1'b0, 32'h0, rd, rsp, w, r0, ts);
        n_vec++;
        if (rd !== 32'h4 || rsp !== 1'b0) begin
            n_miss++;
            $display("FAIL con_off_status: got %h resp=%b, expected 00000004 0", rd, rsp);
        end
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion, expected finish within time limit");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; hsel = 1'b0; htrans = 2'b00; haddr = 32'h0; hsize = 3'd0;
        hwrite = 1'b0; hwdata = 32'h0; con_ready = 1'b0;
        do_reset();
        test_reset();
        test_cycles();
        test_back_to_back();
        test_errors();
        test_tohost_pass();
        do_reset();
        test_tohost_fail();
        do_reset();
`ifdef SCR1_TB_MBOX_CONSOLE_EN
        test_console();
        test_reset_stall();
`else
        test_console_disabled();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/scr1_tb_ahb_mailbox.md
# scr1_tb_ahb_mailbox

AHB-Lite slave for the SCR1 AHB testbench, placed on the core's data-memory AHB port next to `scr1_memory_tb_ahb`, behind the bench address decoder. Firmware reports results through memory-mapped registers rather than by the bench probing the core's register file:
- a test-result ("tohost") register,
- a console byte stream with a small FIFO,
- a free-running cycle counter,
- a status word.

The bench top consumes `test_done`, `test_pass` and `test_code`, and drains the console stream.

## Interface
- `FIFO_DEPTH`, default 8: console FIFO entries. Must be a power of 2, range 2..64.
- `clk`  in  1  bench clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `hsel`  in  1  slave select from the bench decoder.
- `htrans`  in  2  AHB transfer type. Only bit 1 is used: NONSEQ and SEQ are active transfers.
- `haddr`  in  32  address. Only `haddr[3:0]` is decoded.
- `hsize`  in  3  transfer size.
- `hwrite`  in  1  1 = write.
- `hwdata`  in  32  write data, valid in the data phase.
- `hready`  out  1  transfer done / slave ready.
- `hrdata`  out  32  read data.
- `hresp`  out  1  0 = OKAY, 1 = ERROR.
- `test_done`  out  1  sticky; set by the first write to TOHOST.
- `test_pass`  out  1  valid while `test_done` = 1; high when the TOHOST value was 1.
- `test_code`  out  32  value written to TOHOST.
- `con_valid`  out  1  a console byte is available.
- `con_data`  out  8  console byte at the FIFO head.
- `con_ready`  in  1  bench accepts `con_data`.

## Operation
- **Address phase:** captured when `hsel & htrans[1] & hready`. The block registers offset, size and direction. A new address phase may overlap the current data phase (pipelined).
- **Register map**, byte offsets:
  - 0x0 TOHOST, WO.
    - Write value v: `test_done`<=1, `test_code`<=v, `test_pass`<=(v==1).
    - Later writes return OKAY and are ignored.
  - 0x4 CONSOLE, WO.
    - A write pushes `hwdata[7:0]` into the FIFO. The size of the write is irrelevant.
  - 0x8 CYCLES, RO. 32-bit counter, +1 every cycle, wraps from 0xFFFF_FFFF to 0.
  - 0xC STATUS, RO.
    - [0] = `test_done`
    - [1] = FIFO full
    - [2] = FIFO empty
    - [15:8] = FIFO count
    - other bits = 0
- **ERROR response** for any of:
  - `haddr[1:0]` != 0
  - `hsize` > 2
  - read of TOHOST or CONSOLE
  - write of CYCLES or STATUS

  A write that gets ERROR has no side effect.
- **Reads:** zero wait state. `hrdata` is driven in the data phase. CYCLES returns the counter value in the data-phase cycle. `hrdata` = 0 outside read data phases.
- **Console FIFO:**
  - `con_valid` = not empty.
  - A pop occurs on `con_valid & con_ready`.
  - A CONSOLE write completes when the FIFO is not full, or when a pop happens in the same cycle.
  - Push and pop in the same cycle: count unchanged.
- **Reset:** all registers clear, FIFO flushed, counter = 0, any in-flight transfer discarded.

## Timing
- Reset values:
  - `hready`=1, `hresp`=0, `hrdata`=0
  - `test_done`=0, `test_pass`=0, `test_code`=0
  - `con_valid`=0, `con_data`=0
- **Data-phase FSM:** IDLE, XFER, ERR1, ERR2.
  - IDLE/XFER to XFER: an accepted valid access.
  - IDLE/XFER to ERR1: an accepted erroring access.
  - ERR1 outputs `hready`=0, `hresp`=1. Always goes to ERR2.
  - ERR2 outputs `hready`=1, `hresp`=1. Goes to IDLE, or to XFER/ERR1 if a new address phase is accepted in ERR2.
  - XFER returns to IDLE when complete and no new address phase is accepted.
- **Console stall:** in the XFER data phase of a CONSOLE write, `hready` = `~full | (con_valid & con_ready)`, combinational. Stalls with FIFO full last until the bench pops. The push lands on the edge where `hready`=1.
- **TOHOST write:** `test_done` rises on the clock edge ending the data phase. It is visible 1 cycle after the data phase.
- `con_valid` rises 1 cycle after the push edge.
- Reset asserted mid-stall: outputs take reset values on the next edge. The stalled write is lost.

## Configuration
- `SCR1_TB_MBOX_CONSOLE_EN`
  - **Defined:** console FIFO and the CONSOLE register are present as described.
  - **Undefined:**
    - no FIFO
    - `con_valid`=0, `con_data`=0, `con_ready` ignored
    - any CONSOLE access returns ERROR
    - STATUS[2:1] = 2'b10, STATUS[15:8] = 0

## Test plan
- Reset, then read 0xC -> 0x0000_0004. Read 0x8 twice, N cycles apart -> difference N.
- Write 0x1 to 0x0 -> `test_done`=1, `test_pass`=1, `test_code`=1. Then write 0x2 -> outputs unchanged, OKAY.
- Write 0x5 to 0x0 on a fresh reset -> `test_done`=1, `test_pass`=0, `test_code`=5.
- `con_ready`=0, 9 back-to-back writes 0x41..0x49 to 0x4 (depth 8):
  - 9th write stalls with `hready`=0.
  - Raise `con_ready` -> 9th completes in the same cycle as the first pop.
  - `con_data` sequence is 0x41..0x49.
- Read 0x0, write 0xC, and word access to 0x2 -> each gives the 2-cycle ERROR (`hready` 0 then 1, `hresp`=1 both cycles). State unchanged.
- Assert `rst` during a stalled console write -> next cycle `hready`=1, `con_valid`=0, STATUS = 0x4.
